// File: rtl/oport_uart_tx.sv
// Output-port UART transmitter: byte FIFO feeding an 8N1 serial framer.
// Define OPORT_PARITY_EN to add an even-parity bit (8E1 framing).
module oport_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   oport,
  input  logic                         oport_we,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = 16;
  localparam logic [TW-1:0] TimerLast = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   PtrOne    = (AW + 1)'(1);
  localparam logic [AW:0]   FullCount = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef OPORT_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        full, empty;
  logic        push, pop;
  logic [7:0]  head;
  logic        overflow_q, overflow_d;

  assign count_q = wr_ptr_q - rd_ptr_q;
  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign head    = mem[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign push       = oport_we && (!full || pop);
  assign overflow_d = overflow_q || (oport_we && full && !pop);

  assign wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
  assign count_d  = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= oport;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Serial framer
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      data_q, data_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            bit_done;

  assign bit_done = (timer_q == TimerLast);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    pop       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop       = 1'b1;
          data_d    = head;
          state_d   = StStart;
          timer_d   = '0;
          bit_idx_d = '0;
        end
      end
      StStart: begin
        if (bit_done) begin
          timer_d = '0;
          state_d = StData;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StData: begin
        if (bit_done) begin
          timer_d   = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef OPORT_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`ifdef OPORT_PARITY_EN
      StParity: begin
        if (bit_done) begin
          timer_d = '0;
          state_d = StStop;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`endif
      StStop: begin
        if (bit_done) begin
          timer_d = '0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d   = StIdle;
        timer_d   = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // tx and busy are registered from next-state values so they change on the same edge.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_d[bit_idx_d];
`ifdef OPORT_PARITY_EN
      StParity: tx_d = ^data_d;
`endif
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle) || (count_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule
